timer_entry_controller: RTL and testbench

//  User-input side of the egg timer: debounces KEY[1:0], collects MM:SS as BCD from SW[7:0] in two

---
 rtl/timer_entry_controller.sv | 168 ++++++++++++++++
 tb/tb_timer_entry_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/timer_entry_controller.sv
// rtl/timer_entry_controller.sv - egg-timer MM:SS entry: KEY debounce, BCD validation, load handshake, start/stop pulses
// Optional live digit preview while entering: define TIMER_ENTRY_PREVIEW_EN.
module timer_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] KEY,
  input  logic [7:0] SW,
  input  logic       load_ready,
  output logic       load_valid,
  output logic [3:0] minsTens,
  output logic [3:0] minsOnes,
  output logic [3:0] secsTens,
  output logic [3:0] secsOnes,
  output logic       start_pulse,
  output logic       entry_err,
  output logic [1:0] stage
);

  localparam logic [1:0] S_MIN   = 2'd0;
  localparam logic [1:0] S_SEC   = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_ARMED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1_q, sync2_q, stable_q, stable_d, stable_dly_q, press_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // A level change is accepted only after it has been seen unchanged for DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        stable_d[k] = sync2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      stable_q     <= 2'b11;
      stable_dly_q <= 2'b11;
      press_q      <= 2'b00;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
    end else begin
      sync1_q      <= KEY;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
    end
  end

  logic [1:0] state_q, state_d;
  logic [3:0] mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic       lv_q, lv_d, err_q, err_d, start_q, start_d;
  logic       min_ok, sec_ok, all_zero;

  assign min_ok   = (SW[7:4] <= 4'd9) && (SW[3:0] <= 4'd9);
  assign sec_ok   = (SW[7:4] <= 4'd5) && (SW[3:0] <= 4'd9);
  assign all_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (SW == 8'h00);

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    lv_d    = lv_q;
    err_d   = 1'b0;
    start_d = 1'b0;
    case (state_q)
      S_MIN: begin
`ifdef TIMER_ENTRY_PREVIEW_EN
        mt_d = SW[7:4];
        mo_d = SW[3:0];
`endif
        if (press_q[0]) begin
          if (min_ok) begin
            mt_d    = SW[7:4];
            mo_d    = SW[3:0];
            state_d = S_SEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SEC: begin
`ifdef TIMER_ENTRY_PREVIEW_EN
        st_d = SW[7:4];
        so_d = SW[3:0];
`endif
        if (press_q[0]) begin
          if (sec_ok && !all_zero) begin
            st_d    = SW[7:4];
            so_d    = SW[3:0];
            lv_d    = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (lv_q && load_ready) begin
          lv_d    = 1'b0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        // Start/stop wins when both keys land together.
        if (press_q[1]) begin
          start_d = 1'b1;
        end else if (press_q[0]) begin
          state_d = S_MIN;
        end
      end
      default: state_d = S_MIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_MIN;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      lv_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      lv_q    <= lv_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign load_valid  = lv_q;
  assign minsTens    = mt_q;
  assign minsOnes    = mo_q;
  assign secsTens    = st_q;
  assign secsOnes    = so_q;
  assign start_pulse = start_q;
  assign entry_err   = err_q;
  assign stage       = state_q;

endmodule

// File: tb/tb_timer_entry_controller.sv
// tb/tb_timer_entry_controller.sv - directed vector bench for timer_entry_controller (DEBOUNCE_CYCLES=4)
module tb_timer_entry_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] KEY;
  logic [7:0] SW;
  logic       load_ready;
  logic       load_valid, start_pulse, entry_err;
  logic [3:0] minsTens, minsOnes, secsTens, secsOnes;
  logic [1:0] stage;

  int checks = 0;
  int errors = 0;
  int n_err = 0, n_st = 0, n_x = 0;

`ifdef TIMER_ENTRY_PREVIEW_EN
  localparam bit PREV = 1'b1;
`else
  localparam bit PREV = 1'b0;
`endif

  always #5 clk = ~clk;

  timer_entry_controller #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .KEY(KEY), .SW(SW), .load_ready(load_ready),
    .load_valid(load_valid), .minsTens(minsTens), .minsOnes(minsOnes),
    .secsTens(secsTens), .secsOnes(secsOnes), .start_pulse(start_pulse),
    .entry_err(entry_err), .stage(stage)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (entry_err) n_err++;
      if (start_pulse) n_st++;
      if (load_valid && load_ready) n_x++;
    end
  end

  typedef struct {
    logic [7:0]  sw;
    logic        k0, k1, rdy;
    logic [1:0]  stg;
    logic        lv;
    logic [15:0] dig;
    int          err, st, xfer;
  } vec_t;

  vec_t vec [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    int e0, s0, x0;
    @(posedge clk); #1;
    SW = v.sw; load_ready = v.rdy; KEY = {~v.k1, ~v.k0};
    e0 = n_err; s0 = n_st; x0 = n_x;
    repeat (10) @(posedge clk);
    #1 KEY = 2'b11;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d stage", idx), 32'(stage), 32'(v.stg));
    chk($sformatf("v%0d load_valid", idx), 32'(load_valid), 32'(v.lv));
    chk($sformatf("v%0d entry_err", idx), 32'(n_err - e0), 32'(v.err));
    chk($sformatf("v%0d start_pulse", idx), 32'(n_st - s0), 32'(v.st));
    chk($sformatf("v%0d transfers", idx), 32'(n_x - x0), 32'(v.xfer));
    if (!PREV || v.stg >= 2'd2)
      chk($sformatf("v%0d digits", idx), 32'({minsTens, minsOnes, secsTens, secsOnes}), 32'(v.dig));
  endtask

  initial begin
    //          sw     k0 k1 rdy stg  lv dig       err st x
    vec[0]  = '{8'h34, 1, 0, 0, 2'd2, 1, 16'h1234, 0, 0, 0};
    vec[1]  = '{8'h00, 0, 1, 0, 2'd3, 0, 16'h1234, 0, 1, 0};
    vec[2]  = '{8'h00, 1, 1, 0, 2'd3, 0, 16'h1234, 0, 1, 0};
    vec[3]  = '{8'h1A, 1, 0, 0, 2'd0, 0, 16'h1234, 0, 0, 0};
    vec[4]  = '{8'h1A, 1, 0, 0, 2'd0, 0, 16'h1234, 1, 0, 0};
    vec[5]  = '{8'h00, 0, 1, 0, 2'd0, 0, 16'h1234, 0, 0, 0};
    vec[6]  = '{8'h00, 1, 0, 0, 2'd1, 0, 16'h0034, 0, 0, 0};
    vec[7]  = '{8'h60, 1, 0, 0, 2'd1, 0, 16'h0034, 1, 0, 0};
    vec[8]  = '{8'h5A, 1, 0, 0, 2'd1, 0, 16'h0034, 1, 0, 0};
    vec[9]  = '{8'h00, 1, 0, 0, 2'd1, 0, 16'h0034, 1, 0, 0};
    vec[10] = '{8'h05, 1, 0, 0, 2'd2, 1, 16'h0005, 0, 0, 0};
    vec[11] = '{8'h05, 1, 0, 0, 2'd2, 1, 16'h0005, 0, 0, 0};
    vec[12] = '{8'h99, 1, 0, 0, 2'd1, 0, 16'h9900, 0, 0, 0};
    vec[13] = '{8'h59, 1, 0, 1, 2'd3, 0, 16'h9959, 0, 0, 1};
    vec[14] = '{8'h00, 0, 1, 0, 2'd3, 0, 16'h9959, 0, 1, 0};

    reset = 1'b1; KEY = 2'b11; SW = 8'h00; load_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset stage", 32'(stage), 32'd0);
    chk("reset outputs", 32'({load_valid, start_pulse, entry_err}), 32'd0);
    chk("reset digits", 32'({minsTens, minsOnes, secsTens, secsOnes}), 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // short glitch must be ignored, then a real press lands D+3 cycles after the fall
    SW = 8'h12; KEY = 2'b10;
    repeat (3) @(posedge clk);
    #1 KEY = 2'b11;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch stage", 32'(stage), 32'd0);
    @(posedge clk); #1 KEY = 2'b10;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("press latency early", 32'(stage), 32'd0);
    @(negedge clk);
    chk("press latency stage", 32'(stage), 32'd1);
    repeat (2) @(posedge clk);
    #1 KEY = 2'b11;
    repeat (10) @(posedge clk);

    apply(vec[0], 0);
    begin
      int held = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (load_valid && stage == 2'd2) held++;
      end
      chk("load held while not ready", 32'(held), 32'd5);
    end
    begin
      int x0 = n_x;
      @(posedge clk); #1 load_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("handshake stage", 32'(stage), 32'd3);
      chk("handshake load_valid", 32'(load_valid), 32'd0);
      chk("handshake transfers", 32'(n_x - x0), 32'd1);
      #1 load_ready = 1'b0;
    end

    for (int i = 1; i <= 11; i++) apply(vec[i], i);

    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid-load reset load_valid", 32'(load_valid), 32'd0);
    chk("mid-load reset stage", 32'(stage), 32'd0);
    chk("mid-load reset digits", 32'({minsTens, minsOnes, secsTens, secsOnes}), 32'h0);
    #1 reset = 1'b0;

    for (int i = 12; i <= 14; i++) apply(vec[i], i);

`ifdef TIMER_ENTRY_PREVIEW_EN
    @(posedge clk); #1 KEY = 2'b10;
    repeat (10) @(posedge clk);
    #1 KEY = 2'b11; SW = 8'h05;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("preview stage", 32'(stage), 32'd0);
    chk("preview 05", 32'({minsTens, minsOnes}), 32'h05);
    @(posedge clk); #1 SW = 8'h47;
    @(posedge clk);
    @(negedge clk);
    chk("preview 47", 32'({minsTens, minsOnes}), 32'h47);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
